// File: rtl/key_matrix_scan_pkg.sv
// Shared types and constants for the 4x4 key matrix scanner.
// Imported by key_matrix_scan; the tick generator is standalone.
package key_matrix_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int KEY_W = 4;
    localparam logic [ROWS-1:0] ROW_IDLE = 4'b1110;

    // Lowest-index closed column wins when several are low together.
    function automatic logic [1:0] lowest_zero(input logic [COLS-1:0] cols);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (!cols[i]) begin
                idx = i[1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_matrix_scan_tick_gen.sv
// Free-running divider: tick is high for one clk cycle every SCAN_DIV cycles.
// Kept generic so a display row scanner can share it.
module scan_tick_gen #(
    parameter int SCAN_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    logic [15:0] cnt;

    assign tick = (cnt == 16'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 16'd0;
        end else if (tick) begin
            cnt <= 16'd0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/key_matrix_scan.sv
// 4x4 key matrix scanner with tick-based debounce of press and release.
// Define KEY_MATRIX_SCAN_REPEAT_EN to add auto-repeat pulses while a key is held.
module key_matrix_scan
    import key_matrix_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_TICKS = 10,
    parameter int REPEAT_TICKS   = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_TICKS);

    logic        tick;
    logic [3:0]  col_m;
    logic [3:0]  col_s;
    state_t      state;
    logic [1:0]  r;
    logic [1:0]  c;
    logic [7:0]  deb_cnt;
    logic        col_bit;
`ifdef KEY_MATRIX_SCAN_REPEAT_EN
    logic [15:0] rep_cnt;
`endif

    scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_m <= 4'hF;
            col_s <= 4'hF;
        end else begin
            col_m <= col_in;
            col_s <= col_m;
        end
    end

    // Once a key is locked only its own row/column is watched.
    assign col_bit = col_s[c];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            row_out   <= ROW_IDLE;
            r         <= 2'd0;
            c         <= 2'd0;
            deb_cnt   <= 8'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEY_MATRIX_SCAN_REPEAT_EN
            rep_cnt   <= 16'd0;
`endif
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (col_s == 4'hF) begin
                            r       <= r + 2'd1;
                            row_out <= {row_out[2:0], row_out[3]};
                        end else begin
                            c       <= lowest_zero(col_s);
                            deb_cnt <= 8'd0;
                            state   <= DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (col_bit) begin
                            state   <= SCAN;
                            r       <= r + 2'd1;
                            row_out <= {row_out[2:0], row_out[3]};
                        end else if (deb_cnt >= DEB_LAST) begin
                            state     <= PRESSED;
                            key_code  <= {r, c};
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
`ifdef KEY_MATRIX_SCAN_REPEAT_EN
                            rep_cnt   <= 16'd0;
`endif
                        end else if (deb_cnt != 8'hFF) begin
                            deb_cnt <= deb_cnt + 8'd1;
                        end
                    end
                    PRESSED: begin
                        if (col_bit) begin
                            deb_cnt <= 8'd0;
                            state   <= RELEASE;
                        end
`ifdef KEY_MATRIX_SCAN_REPEAT_EN
                        else if (rep_cnt >= 16'(REPEAT_TICKS - 1)) begin
                            rep_cnt   <= 16'd0;
                            key_valid <= 1'b1;
                        end else begin
                            rep_cnt <= rep_cnt + 16'd1;
                        end
`endif
                    end
                    RELEASE: begin
                        if (!col_bit) begin
                            state <= PRESSED;
`ifdef KEY_MATRIX_SCAN_REPEAT_EN
                            rep_cnt <= 16'd0;
`endif
                        end else if (deb_cnt >= DEB_LAST) begin
                            key_held <= 1'b0;
                            state    <= SCAN;
                            r        <= r + 2'd1;
                            row_out  <= {row_out[2:0], row_out[3]};
                        end else if (deb_cnt != 8'hFF) begin
                            deb_cnt <= deb_cnt + 8'd1;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_matrix_scan.sv
// Self-checking bench: physical key matrix model driving col_in from row_out,
// plus a tick-level reference of the scan/debounce rules.
module tb_key_matrix_scan;

    localparam int SDIV = 4;
    localparam int DEB  = 3;
    localparam int REP  = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [15:0] keys;

    int errors = 0;
    int checks = 0;

    // reference state: row being scanned, locked key, run of agreeing samples
    int         m_row;
    bit         m_locked;
    bit         m_held;
    int         m_run;
    int         m_rep;
    logic [1:0] m_lr;
    logic [1:0] m_lc;
    logic [3:0] m_code;
    logic       m_valid;

    key_matrix_scan #(
        .SCAN_DIV       (SDIV),
        .DEBOUNCE_TICKS (DEB),
        .REPEAT_TICKS   (REP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // A closed key pulls its column low when its row is driven low.
    always_comb begin
        col_in = 4'hF;
        for (int rr = 0; rr < 4; rr++) begin
            for (int cc = 0; cc < 4; cc++) begin
                if (row_out[rr] == 1'b0 && keys[rr*4+cc]) begin
                    col_in[cc] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, want, $time);
        end
    endtask

    task automatic model_reset();
        m_row = 0; m_locked = 0; m_held = 0; m_run = 0; m_rep = 0;
        m_lr = 2'd0; m_lc = 2'd0; m_code = 4'd0; m_valid = 1'b0;
    endtask

    task automatic model_tick();
        bit closed;
        bit any;
        m_valid = 1'b0;
        if (!m_locked) begin
            any = 0;
            for (int cc = 3; cc >= 0; cc--) begin
                if (keys[m_row*4+cc]) begin
                    any  = 1;
                    m_lc = 2'(cc);
                end
            end
            if (!any) begin
                m_row = (m_row + 1) % 4;
            end else begin
                m_locked = 1;
                m_lr     = 2'(m_row);
                m_run    = 1;
            end
        end else begin
            closed = keys[{m_lr, m_lc}];
            if (!m_held) begin
                if (closed) begin
                    m_run++;
                    if (m_run == DEB + 2) begin
                        m_held = 1; m_code = {m_lr, m_lc}; m_valid = 1'b1;
                        m_run = 0; m_rep = 0;
                    end
                end else begin
                    m_locked = 0;
                    m_row = (m_row + 1) % 4;
                end
            end else if (!closed) begin
                m_run++;
                if (m_run == DEB + 2) begin
                    m_held = 0; m_locked = 0; m_run = 0;
                    m_row = (m_row + 1) % 4;
                end
            end else if (m_run > 0) begin
                m_run = 0;
                m_rep = 0;
            end else begin
`ifdef KEY_MATRIX_SCAN_REPEAT_EN
                m_rep++;
                if (m_rep == REP) begin
                    m_valid = 1'b1;
                    m_rep = 0;
                end
`endif
            end
        end
    endtask

    // One scan period; compares outputs just after the tick edge.
    task automatic step_tick();
        for (int i = 0; i < SDIV; i++) begin
            @(posedge clk);
            #1;
            if (i < SDIV - 1) begin
                chk("valid_between_ticks", {3'b0, key_valid}, 4'd0);
            end else begin
                model_tick();
                chk("row_out", row_out, ~(4'b0001 << m_row));
                chk("key_code", key_code, m_code);
                chk("key_valid", {3'b0, key_valid}, {3'b0, m_valid});
                chk("key_held", {3'b0, key_held}, {3'b0, m_held});
            end
        end
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) step_tick();
    endtask

    task automatic go_to_row(input int target);
        for (int i = 0; i < 4 && m_row != target; i++) step_tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_row"}, row_out, 4'b1110);
        chk({tag, "_code"}, key_code, 4'd0);
        chk({tag, "_valid"}, {3'b0, key_valid}, 4'd0);
        chk({tag, "_held"}, {3'b0, key_held}, 4'd0);
    endtask

    initial begin
        keys  = 16'h0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // idle scan
        run_ticks(5);

        // key r2 c2 held steadily, then released
        go_to_row(2);
        keys = 16'h0400;
        run_ticks(10);
        chk("hold_code_A", key_code, 4'hA);
        keys = 16'h0;
        run_ticks(7);

        // short bounce on r1 c0
        go_to_row(1);
        keys = 16'h0010;
        step_tick();
        keys = 16'h0;
        run_ticks(3);

        // release with a one-tick re-closure
        go_to_row(3);
        keys = 16'h8000;
        run_ticks(7);
        keys = 16'h0;
        step_tick();
        keys = 16'h8000;
        step_tick();
        keys = 16'h0;
        run_ticks(7);

        // two columns on row 0, reset while held
        go_to_row(0);
        keys = 16'h000A;
        run_ticks(8);
        chk("multi_col_code", key_code, 4'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        keys = 16'h0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_ticks(3);

        // hold r1 c1 long enough to see repeat behaviour when enabled
        go_to_row(1);
        keys = 16'h0020;
        run_ticks(20);
        keys = 16'h0;
        run_ticks(8);

        // random key activity
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0:       keys = 16'h0;
                    1:       keys = 16'h1 << $urandom_range(0, 15);
                    default: keys = 16'($urandom) & 16'($urandom);
                endcase
            end
            step_tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
